lifo_stack_param: RTL and testbench

- Parametrised successor to the team's fixed 8x8 linear stack (LIFO).
- Generic data width and depth; single-cycle simultaneous push+pop (swap/pass-through); combinational top-of-stack peek; occupancy count; programmable almost-full/almost-empty flags; sticky overflow/underflow error flags.
- Used as a local scratch/return stack inside datapath blocks. One clock domain.

---
 rtl/lifo_pkg.sv | 14 +
 rtl/lifo_mem.sv | 25 ++
 rtl/lifo_stack_param.sv | 99 +++++++++
 tb/tb_lifo_stack_param.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lifo_pkg.sv
// rtl/lifo_pkg.sv - shared defaults and count-width helper for the parametrised LIFO stack
package lifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 8;
    localparam int DEFAULT_AF_LEVEL   = 6;
    localparam int DEFAULT_AE_LEVEL   = 2;

    // Occupancy runs 0..depth inclusive, so a power-of-two depth needs one extra bit.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lifo_mem.sv
// rtl/lifo_mem.sv - DEPTH x DATA_WIDTH register array, one write port, one async read port
module lifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lifo_stack_param.sv
// rtl/lifo_stack_param.sv - parametrised LIFO with swap/pass-through, peek, level flags and sticky errors
module lifo_stack_param
    import lifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int AF_LEVEL   = DEFAULT_AF_LEVEL,
    parameter int AE_LEVEL   = DEFAULT_AE_LEVEL,
    localparam int CW        = count_width(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  err_clr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] top,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0]         top_idx;
    logic [AW-1:0]         rd_addr;
    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_en;
    logic                  do_swap;
    logic                  do_pass;
    logic                  push_ok;
    logic                  push_rej;
    logic                  pop_ok;
    logic                  pop_rej;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    assign do_swap  = push &  pop & !empty;
    assign do_pass  = push &  pop &  empty;
    assign push_ok  = push & !pop & !full;
    assign push_rej = push & !pop &  full;
    assign pop_ok   = pop  & !push & !empty;
    assign pop_rej  = pop  & !push &  empty;

    assign top_idx = count - CW'(1);
    // Address 0 when empty keeps the read in range; the value is masked off below.
    assign rd_addr = empty ? '0 : top_idx[AW-1:0];
    assign wr_addr = do_swap ? top_idx[AW-1:0] : count[AW-1:0];
    // Qualified by reset so an edge seen while reset is held never lands a write.
    assign wr_en   = reset & (do_swap | push_ok);
    assign top     = empty ? '0 : rd_data;

    lifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (data_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            data_out  <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= do_swap | do_pass | pop_ok;
            if (do_swap || pop_ok) begin
                data_out <= rd_data;
            end else if (do_pass) begin
                data_out <= data_in;
            end
            if (push_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok) begin
                count <= count - CW'(1);
            end
            overflow  <= push_rej | (overflow  & !err_clr);
            underflow <= pop_rej  | (underflow & !err_clr);
        end
    end

endmodule

// File: tb/tb_lifo_stack_param.sv
// tb/tb_lifo_stack_param.sv - directed self-checking bench for lifo_stack_param
module tb_lifo_stack_param;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic [DW-1:0] top;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int failures = 0;

    lifo_stack_param #(
        .DATA_WIDTH (8),
        .DEPTH      (8),
        .AF_LEVEL   (6),
        .AE_LEVEL   (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .err_clr      (err_clr),
        .data_in      (data_in),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .top          (top),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic p, input logic q, input logic [DW-1:0] d);
        push = p;
        pop = q;
        data_in = d;
        tick();
        push = 1'b0;
        pop = 1'b0;
    endtask

    logic [DW-1:0] exp_pop [8];

    initial begin
        tick();
        tick();
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_ae", 32'(almost_empty), 1);
        check("rst_af", 32'(almost_full), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_data_out", 32'(data_out), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_udf", 32'(underflow), 0);
        check("rst_top", 32'(top), 0);
        reset = 1'b1;

        drive(1, 0, 8'h11);
        check("push1_rd_valid", 32'(rd_valid), 0);
        drive(1, 0, 8'h22);
        drive(1, 0, 8'h33);
        check("p3_count", 32'(count), 3);
        check("p3_top", 32'(top), 32'h33);
        drive(0, 1, 8'h00);
        check("pop1_data", 32'(data_out), 32'h33);
        check("pop1_valid", 32'(rd_valid), 1);
        check("pop1_top", 32'(top), 32'h22);
        drive(0, 1, 8'h00);
        check("pop2_data", 32'(data_out), 32'h22);
        drive(0, 1, 8'h00);
        check("pop3_data", 32'(data_out), 32'h11);
        check("pop3_valid", 32'(rd_valid), 1);
        check("pop3_empty", 32'(empty), 1);
        tick();
        check("idle_valid", 32'(rd_valid), 0);
        check("idle_hold", 32'(data_out), 32'h11);

        drive(0, 1, 8'h00);
        check("udf_flag", 32'(underflow), 1);
        check("udf_valid", 32'(rd_valid), 0);
        check("udf_hold", 32'(data_out), 32'h11);
        check("udf_count", 32'(count), 0);
        tick();
        check("udf_sticky", 32'(underflow), 1);
        err_clr = 1'b1;
        drive(0, 1, 8'h00);
        check("udf_set_wins", 32'(underflow), 1);
        tick();
        err_clr = 1'b0;
        check("udf_clr", 32'(underflow), 0);

        for (int k = 0; k < 8; k++) begin
            check($sformatf("lvl%0d_count", k), 32'(count), 32'(k));
            check($sformatf("lvl%0d_ae", k), 32'(almost_empty), (k <= 2) ? 1 : 0);
            check($sformatf("lvl%0d_af", k), 32'(almost_full), (k >= 6) ? 1 : 0);
            check($sformatf("lvl%0d_full", k), 32'(full), 0);
            drive(1, 0, 8'(k + 1));
        end
        check("lvl8_count", 32'(count), 8);
        check("lvl8_ae", 32'(almost_empty), 0);
        check("lvl8_af", 32'(almost_full), 1);
        check("lvl8_full", 32'(full), 1);

        drive(1, 0, 8'hAA);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_full", 32'(full), 1);
        check("ovf_count", 32'(count), 8);
        check("ovf_top", 32'(top), 32'h08);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 0);

        drive(1, 1, 8'h99);
        check("fswap_data", 32'(data_out), 32'h08);
        check("fswap_valid", 32'(rd_valid), 1);
        check("fswap_count", 32'(count), 8);
        check("fswap_top", 32'(top), 32'h99);
        check("fswap_ovf", 32'(overflow), 0);

        exp_pop = '{8'h99, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 8'h00);
            check($sformatf("drain%0d_data", k), 32'(data_out), 32'(exp_pop[k]));
            check($sformatf("drain%0d_count", k), 32'(count), 32'(7 - k));
        end
        check("drain_empty", 32'(empty), 1);

        drive(1, 0, 8'h11);
        drive(1, 0, 8'h22);
        drive(1, 0, 8'h33);
        drive(1, 1, 8'h44);
        check("swap_data", 32'(data_out), 32'h33);
        check("swap_valid", 32'(rd_valid), 1);
        check("swap_count", 32'(count), 3);
        check("swap_top", 32'(top), 32'h44);
        drive(0, 1, 8'h00);
        check("swap_pop1", 32'(data_out), 32'h44);
        drive(0, 1, 8'h00);
        check("swap_pop2", 32'(data_out), 32'h22);
        drive(0, 1, 8'h00);
        check("swap_pop3", 32'(data_out), 32'h11);

        drive(1, 1, 8'h5A);
        check("pass_data", 32'(data_out), 32'h5A);
        check("pass_valid", 32'(rd_valid), 1);
        check("pass_count", 32'(count), 0);
        check("pass_ovf", 32'(overflow), 0);
        check("pass_udf", 32'(underflow), 0);
        check("pass_top", 32'(top), 0);

        drive(1, 0, 8'h77);
        drive(1, 0, 8'h66);
        check("pre_rst_count", 32'(count), 2);
        push = 1'b1;
        data_in = 8'hEE;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 0);
        check("async_rst_empty", 32'(empty), 1);
        check("async_rst_data", 32'(data_out), 0);
        tick();
        check("rst_push_count", 32'(count), 0);
        check("rst_push_top", 32'(top), 0);
        push = 1'b0;
        reset = 1'b1;
        tick();
        check("post_rst_count", 32'(count), 0);
        check("post_rst_valid", 32'(rd_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
